// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result bundle between the CPU control path and alu_seq.
//
// Signals:
//   start     request from the CPU, only looked at while busy is low
//   select    3-bit opcode, captured together with start
//   op1, op2  WIDTH-bit operands, captured together with start
//   result    registered WIDTH-bit result
//   zero      registered flag, result == 0
//   carry     registered carry-out of ADD
//   overflow  registered signed overflow of ADD
//   busy      high while a multiply is in flight
//   done      one-cycle pulse when result/flags were just updated
//
// Modports:
//   master  the requester (CPU control / testbench)
//   slave   the ALU itself
interface alu_seq_if #(
  parameter int WIDTH = 8
) ();

  logic             start;
  logic [2:0]       select;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             overflow;
  logic             busy;
  logic             done;

  modport master (
    output start, select, op1, op2,
    input  result, zero, carry, overflow, busy, done
  );

  modport slave (
    input  start, select, op1, op2,
    output result, zero, carry, overflow, busy, done
  );

endinterface

// File: rtl/alu_seq.sv
// alu_seq: clocked WIDTH-bit ALU with a start/busy/done handshake.
// Single-cycle ops (FWD, ADD, AND, OR, SRA, SLL, SRL) complete at the edge
// that accepts start. MUL runs an iterative shift-add, one multiplier bit per
// cycle, and completes WIDTH cycles after the accepting edge.
//
// Ports:
//   CLK    rising-edge clock
//   RESET  synchronous, active-high reset
//   bus    alu_seq_if slave modport (start/select/op1/op2 in,
//          result/zero/carry/overflow/busy/done out)
//
// Opcodes: 000 FWD, 001 ADD, 010 AND, 011 OR, 100 SRA, 101 SLL, 110 MUL, 111 SRL
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic     CLK,
  input  logic     RESET,
  alu_seq_if.slave bus
);

  localparam logic [2:0]     OP_FWD = 3'b000;
  localparam logic [2:0]     OP_ADD = 3'b001;
  localparam logic [2:0]     OP_AND = 3'b010;
  localparam logic [2:0]     OP_OR  = 3'b011;
  localparam logic [2:0]     OP_SRA = 3'b100;
  localparam logic [2:0]     OP_SLL = 3'b101;
  localparam logic [2:0]     OP_MUL = 3'b110;
  localparam logic [2:0]     OP_SRL = 3'b111;
  localparam logic [SHW-1:0] LAST   = SHW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  state_t state;
  state_t stateNext;

  // Multiplier datapath
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   cnt;

  // Registered outputs
  logic [WIDTH-1:0] resultQ;
  logic             zeroQ;
  logic             carryQ;
  logic             overflowQ;
  logic             doneQ;

  // Combinational decisions
  logic             singleDone;
  logic             mulStart;
  logic             mulLast;
  logic [WIDTH-1:0] accNext;
  logic [WIDTH-1:0] aluResult;
  logic             aluCarry;
  logic             aluOverflow;
  logic [WIDTH:0]   sum;
  logic             bigShift;
  logic [SHW-1:0]   shamt;

  // State register: reset aborts any multiply in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state: only a MUL request leaves IDLE; MUL returns after its
  // WIDTH-th iteration. Starts seen in MUL are dropped.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (bus.start && (bus.select == OP_MUL)) begin
          stateNext = MUL;
        end
      end
      MUL: begin
        if (cnt == LAST) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Output/datapath decode: the single-cycle result is computed straight
  // from the live inputs, and the accumulator's next value includes the
  // current multiplier bit so the final iteration can publish it directly.
  always_comb begin
    sum         = {1'b0, bus.op1} + {1'b0, bus.op2};
    // op2 >= WIDTH exactly when any bit above the shift field is set
    bigShift    = |bus.op2[WIDTH-1:SHW];
    shamt       = bus.op2[SHW-1:0];
    accNext     = acc + (mplier[0] ? mcand : '0);
    aluResult   = '0;
    aluCarry    = 1'b0;
    aluOverflow = 1'b0;
    case (bus.select)
      OP_FWD: aluResult = bus.op2;
      OP_ADD: begin
        aluResult   = sum[WIDTH-1:0];
        aluCarry    = sum[WIDTH];
        aluOverflow = (bus.op1[WIDTH-1] == bus.op2[WIDTH-1]) &&
                      (sum[WIDTH-1] != bus.op1[WIDTH-1]);
      end
      OP_AND: aluResult = bus.op1 & bus.op2;
      OP_OR:  aluResult = bus.op1 | bus.op2;
      OP_SRA: aluResult = bigShift ? {WIDTH{bus.op1[WIDTH-1]}}
                                   : WIDTH'($signed(bus.op1) >>> shamt);
      OP_SLL: aluResult = bigShift ? '0 : (bus.op1 << shamt);
      OP_SRL: aluResult = bigShift ? '0 : (bus.op1 >> shamt);
      default: aluResult = '0;
    endcase
    singleDone = (state == IDLE) && bus.start && (bus.select != OP_MUL);
    mulStart   = (state == IDLE) && bus.start && (bus.select == OP_MUL);
    mulLast    = (state == MUL) && (cnt == LAST);
  end

  // Datapath registers: result/flags change only on a done edge, so they
  // hold between completions; done defaults low for a one-cycle pulse.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      resultQ   <= '0;
      zeroQ     <= 1'b1;
      carryQ    <= 1'b0;
      overflowQ <= 1'b0;
      doneQ     <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      doneQ <= 1'b0;
      if (singleDone) begin
        resultQ   <= aluResult;
        zeroQ     <= (aluResult == '0);
        carryQ    <= aluCarry;
        overflowQ <= aluOverflow;
        doneQ     <= 1'b1;
      end
      if (mulStart) begin
        mcand  <= bus.op1;
        mplier <= bus.op2;
        acc    <= '0;
        cnt    <= '0;
      end
      if (state == MUL) begin
        acc    <= accNext;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (mulLast) begin
          resultQ   <= accNext;
          zeroQ     <= (accNext == '0);
          carryQ    <= 1'b0;
          overflowQ <= 1'b0;
          doneQ     <= 1'b1;
        end
      end
    end
  end

  assign bus.result   = resultQ;
  assign bus.zero     = zeroQ;
  assign bus.carry    = carryQ;
  assign bus.overflow = overflowQ;
  assign bus.done     = doneQ;
  assign bus.busy     = (state == MUL);

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq at WIDTH=8.
// Directed steps followed by randomized ops, all compared against a
// behavioural model built from integer arithmetic.
module tb_alu_seq;

  localparam int WIDTH = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  int         checks = 0;
  int         errors = 0;
  logic [12:0] lastStatus;
  logic [2:0]  rSel;
  logic [7:0]  rA;
  logic [7:0]  rB;

  alu_seq_if #(.WIDTH(WIDTH)) bus ();

  alu_seq #(.WIDTH(WIDTH)) dut (
    .CLK   (clock),
    .RESET (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 time-unit period
  always #5 clock = ~clock;

  // Packed view of every output: {done, busy, zero, carry, overflow, result}
  function automatic logic [12:0] observed();
    return {bus.done, bus.busy, bus.zero, bus.carry, bus.overflow, bus.result};
  endfunction

  // Reference model: expected status right after a completing edge
  function automatic logic [12:0] refStatus(input logic [2:0] sel,
                                            input logic [7:0] a,
                                            input logic [7:0] b);
    int   ua;
    int   ub;
    int   sa;
    int   sb;
    int   r;
    logic c;
    logic o;
    logic [7:0] res;
    ua = int'(a);
    ub = int'(b);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    c  = 1'b0;
    o  = 1'b0;
    case (sel)
      3'd0: r = ub;
      3'd1: begin
        r = ua + ub;
        c = (r > 255);
        o = ((sa + sb) > 127) || ((sa + sb) < -128);
      end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = (ub >= 8) ? ((sa < 0) ? -1 : 0) : (sa >>> ub);
      3'd5: r = (ub >= 8) ? 0 : (ua << ub);
      3'd6: r = ua * ub;
      default: r = (ub >= 8) ? 0 : (ua >> ub);
    endcase
    res = r[7:0];
    return {1'b1, 1'b0, (res == 8'h00), c, o, res};
  endfunction

  task automatic checkOutput(input string tag, input logic [12:0] obs,
                             input logic [12:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [2:0] sel,
                               input logic [7:0] a, input logic [7:0] b);
    bus.start  = s;
    bus.select = sel;
    bus.op1    = a;
    bus.op2    = b;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue a single-cycle op; start is left asserted so a following call
  // forms a back-to-back request.
  task automatic singleOp(input string tag, input logic [2:0] sel,
                          input logic [7:0] a, input logic [7:0] b);
    applyStimulus(1'b1, sel, a, b);
    tick();
    lastStatus = refStatus(sel, a, b);
    checkOutput(tag, observed(), lastStatus);
  endtask

  // One cycle with no request: done low, everything else held
  task automatic idleCycle(input string tag);
    applyStimulus(1'b0, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
    tick();
    checkOutput(tag, observed(), {2'b00, lastStatus[10:0]});
  endtask

  // Multiply with busy tracked every cycle. A competing start is raised at
  // cycle intrudeAt (values outside 1..7 mean none); other cycles wiggle
  // the inputs with start low.
  task automatic runMul(input string tag, input logic [7:0] a,
                        input logic [7:0] b, input int intrudeAt);
    applyStimulus(1'b1, 3'b110, a, b);
    tick();
    checkOutput({tag, "_accept"}, observed(), {2'b01, lastStatus[10:0]});
    for (int k = 1; k < WIDTH; k++) begin
      if (k == intrudeAt) begin
        applyStimulus(1'b1, 3'b010, 8'($urandom), 8'($urandom));
      end else begin
        applyStimulus(1'b0, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      end
      tick();
      checkOutput({tag, "_busy"}, observed(), {2'b01, lastStatus[10:0]});
    end
    applyStimulus(1'b0, 3'b000, 8'h00, 8'h00);
    tick();
    lastStatus = refStatus(3'b110, a, b);
    checkOutput({tag, "_done"}, observed(), lastStatus);
  endtask

  initial begin
    // Reset held for two cycles
    applyStimulus(1'b0, 3'b000, 8'h00, 8'h00);
    reset = 1'b1;
    tick();
    tick();
    lastStatus = {5'b00100, 8'h00};
    checkOutput("reset_state", observed(), lastStatus);
    reset = 1'b0;

    // ADD wrapping to zero with carry
    singleOp("add_ff_01", 3'b001, 8'hFF, 8'h01);
    checkOutput("add_ff_01_lit", observed(), {5'b10110, 8'h00});
    idleCycle("add_ff_01_hold");

    // Signed overflow then back-to-back FWD
    singleOp("add_100_50", 3'b001, 8'd100, 8'd50);
    checkOutput("add_100_50_lit", observed(), {5'b10001, 8'h96});
    singleOp("fwd_3c", 3'b000, 8'h5A, 8'h3C);
    checkOutput("fwd_3c_lit", observed(), {5'b10000, 8'h3C});
    idleCycle("fwd_hold");

    // MUL with an ignored AND request at cycle 3
    runMul("mul_12x11", 8'd12, 8'd11, 3);
    checkOutput("mul_12x11_lit", observed(), {5'b10000, 8'h84});
    idleCycle("mul_12x11_hold");
    idleCycle("mul_12x11_hold2");

    // Signed operand and a product that vanishes in the low half
    runMul("mul_fd_5", 8'hFD, 8'd5, 0);
    checkOutput("mul_fd_5_lit", observed(), {5'b10000, 8'hF1});
    runMul("mul_10_10", 8'h10, 8'h10, 0);
    checkOutput("mul_10_10_lit", observed(), {5'b10100, 8'h00});
    idleCycle("mul_10_10_hold");

    // Shifts, including amounts at or beyond WIDTH
    singleOp("sra_80_3", 3'b100, 8'h80, 8'd3);
    checkOutput("sra_80_3_lit", observed(), {5'b10000, 8'hF0});
    singleOp("srl_80_3", 3'b111, 8'h80, 8'd3);
    checkOutput("srl_80_3_lit", observed(), {5'b10000, 8'h10});
    singleOp("sll_81_1", 3'b101, 8'h81, 8'd1);
    checkOutput("sll_81_1_lit", observed(), {5'b10000, 8'h02});
    singleOp("sll_81_9", 3'b101, 8'h81, 8'd9);
    checkOutput("sll_81_9_lit", observed(), {5'b10100, 8'h00});
    singleOp("sra_80_200", 3'b100, 8'h80, 8'd200);
    checkOutput("sra_80_200_lit", observed(), {5'b10000, 8'hFF});
    singleOp("sra_7f_8", 3'b100, 8'h7F, 8'd8);
    singleOp("srl_ff_7", 3'b111, 8'hFF, 8'd7);
    idleCycle("shift_hold");

    // Reset in the middle of a multiply
    applyStimulus(1'b1, 3'b110, 8'd7, 8'd9);
    tick();
    applyStimulus(1'b0, 3'b000, 8'h00, 8'h00);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    lastStatus = {5'b00100, 8'h00};
    checkOutput("mul_reset", observed(), lastStatus);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      idleCycle("post_reset_no_done");
    end
    singleOp("add_2_3", 3'b001, 8'd2, 8'd3);
    checkOutput("add_2_3_lit", observed(), {5'b10000, 8'h05});
    idleCycle("add_2_3_hold");

    // Randomized mix, including back-to-back requests
    for (int i = 0; i < 80; i++) begin
      rSel = 3'($urandom_range(0, 7));
      rA   = 8'($urandom);
      rB   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
      if (rSel == 3'b110) begin
        runMul("rand_mul", rA, rB, int'($urandom_range(1, 12)));
      end else begin
        singleOp("rand_op", rSel, rA, rB);
        if ($urandom_range(0, 1) == 1) begin
          idleCycle("rand_idle");
        end
      end
    end
    idleCycle("final_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, clocked successor to the CPU's 8-bit combinational ALU. Generalised to WIDTH bits.
- Operands and opcode are captured through a start/busy/done handshake. Result and flags are registered.
- Multiply is an iterative shift-add unit, one bit per cycle, instead of combinational.
- Adds carry/overflow flags and an arithmetic-right-shift opcode. Sits between the register file read ports and the writeback mux; the CPU control unit stalls on busy.

Parameters:
- WIDTH, 8, operand/result width in bits (power of two, ≥4)
- SHW, $clog2(WIDTH), width of the shift-amount field taken from op2

Ports:
- CLK  input  1  clock; all state changes on rising edge
- RESET  input  1  synchronous, active-high reset
- start  input  1  request; sampled only while busy=0
- select  input  3  opcode, captured with start
- op1  input  WIDTH  operand 1 (two's complement), captured with start
- op2  input  WIDTH  operand 2, captured with start
- result  output  WIDTH  registered result
- zero  output  1  registered: result == 0
- carry  output  1  registered carry-out (ADD only)
- overflow  output  1  registered signed overflow (ADD only)
- busy  output  1  high while a multi-cycle op is in progress
- done  output  1  one-cycle pulse: result and flags updated this cycle

Behaviour:
- Reset (synchronous, priority over everything): result=0, zero=1, carry=0, overflow=0, busy=0, done=0; FSM→IDLE. Reset mid-multiply aborts it with no done pulse.
- Opcodes (same encoding as existing ALU):
  - 000 FWD: op2
  - 001 ADD: op1+op2; subtraction is done by the caller negating op2
  - 010 AND
  - 011 OR
  - 100 SRA: op1 >>> op2
  - 101 SLL: op1 << op2
  - 110 MUL: low WIDTH bits of op1*op2
  - 111 SRL: op1 >> op2
- Shift amount: op2 as unsigned. If op2 ≥ WIDTH, SLL/SRL give 0 and SRA gives all copies of op1[WIDTH-1].
- States: IDLE, MUL.
- IDLE, start=1, select≠110: at that edge, result/flags written and done=1 (1-cycle latency). busy stays 0. Back-to-back starts on consecutive cycles are legal; each produces its own done.
- IDLE, start=1, select=110: at that edge, op1/op2 latched into multiplicand/multiplier registers, accumulator cleared, counter=0, busy=1, → MUL.
- MUL: each cycle, if multiplier LSB=1, accumulator += multiplicand (mod 2^WIDTH); multiplicand <<1, multiplier >>1, counter+1.
  - On the WIDTH-th MUL cycle: result=accumulator, flags written, done=1, busy=0, → IDLE.
  - Total latency from start edge to done edge = WIDTH cycles.
- start while busy=1 is ignored entirely (not queued). Input changes during MUL have no effect.
- Flags:
  - zero = (new result == 0) for every op.
  - carry = bit WIDTH of the unsigned (WIDTH+1)-bit sum, ADD only.
  - overflow = operands same sign and sum sign differs, ADD only.
  - carry and overflow are cleared by every non-ADD op.
- result/flags hold their value between done pulses. done is high for exactly one cycle per accepted start.
- Signed and unsigned MUL give identical low WIDTH bits; no high half is produced.

Test Plan (WIDTH=8):
1. RESET for 2 cycles, then start ADD 0xFF+0x01 → next cycle done=1, result=0x00, zero=1, carry=1, overflow=0, busy=0 throughout.
2. ADD 100+50 → result=0x96, overflow=1, carry=0, zero=0. Then FWD op2=0x3C on the very next cycle → result=0x3C, carry=0, overflow=0, two consecutive done pulses.
3. MUL 12*11 → busy=1 for 8 cycles, done exactly 8 cycles after the start edge, result=0x84. A start(AND) issued at cycle 3 is ignored: only one done, result unchanged.
4. MUL 0xFD*5 (−3*5) → result=0xF1. MUL 0x10*0x10 → result=0x00, zero=1.
5. SRA 0x80 by 3 → 0xF0. SRL 0x80 by 3 → 0x10. SLL 0x81 by 1 → 0x02. SLL 0x81 by 9 → 0x00, zero=1. SRA 0x80 by 200 → 0xFF.
6. MUL 7*9 with RESET asserted at cycle 4 → next cycle busy=0, done never pulses, result=0, zero=1. A fresh ADD 2+3 afterwards → 0x05 with 1-cycle latency.
